// File: rtl/interconnect_pkg.sv
// Shared types and constants for the round-robin APB interconnect.
package interconnect_pkg;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEPTH_FIFO = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_grant_sel.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_grant_sel #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned PORT_W    = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PORT_W-1:0]    ptr,
  output logic [NUM_PORTS-1:0] gnt_onehot,
  output logic [PORT_W-1:0]    gnt_idx,
  output logic                 any
);

  always_comb begin
    logic [PORT_W-1:0] cand;
    cand    = '0;
    any     = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      cand = PORT_W'((int'(ptr) + i) % int'(NUM_PORTS));
      if (!any && req[cand]) begin
        any     = 1'b1;
        gnt_idx = cand;
      end
    end
    gnt_onehot = any ? (NUM_PORTS'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/apb_rr_arbiter.sv
// Pops one non-empty FIFO per transaction in round-robin order and replays it
// as a single APB3 transfer, returning completion status tagged with the port.
module apb_rr_arbiter
  import interconnect_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned PORT_W    = $clog2(NUM_PORTS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        fifo_empty_i,
  input  logic [NUM_PORTS*ADDR_W-1:0] fifo_addr_i,
  input  logic [NUM_PORTS*DATA_W-1:0] fifo_wdata_i,
  input  logic [NUM_PORTS-1:0]        fifo_write_i,
  output logic [NUM_PORTS-1:0]        fifo_pop_o,
  output logic                        m_psel_o,
  output logic                        m_penable_o,
  output logic                        m_pwrite_o,
  output logic [ADDR_W-1:0]           m_paddr_o,
  output logic [DATA_W-1:0]           m_pwdata_o,
  input  logic [DATA_W-1:0]           m_prdata_i,
  input  logic                        m_pready_i,
  input  logic                        m_pslverr_i,
  output logic                        rsp_valid_o,
  output logic [PORT_W-1:0]           rsp_port_o,
  output logic [DATA_W-1:0]           rsp_rdata_o,
  output logic                        rsp_err_o
);

  arb_state_t state, state_nxt;

  logic [PORT_W-1:0]    ptr;
  logic [PORT_W-1:0]    gnt_q;
  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] gnt_onehot;
  logic [PORT_W-1:0]    gnt_idx;
  logic                 any;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_wdata;
  logic                 sel_write;

  assign req = ~fifo_empty_i;

  rr_grant_sel #(
    .NUM_PORTS (NUM_PORTS),
    .PORT_W    (PORT_W)
  ) u_grant_sel (
    .req        (req),
    .ptr        (ptr),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (any)
  );

  // Head entry of the granted FIFO; only meaningful while its pop is high.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_write = 1'b0;
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      if (gnt_idx == PORT_W'(i)) begin
        sel_addr  = fifo_addr_i[i*ADDR_W +: ADDR_W];
        sel_wdata = fifo_wdata_i[i*DATA_W +: DATA_W];
        sel_write = fifo_write_i[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    fifo_pop_o = '0;
    case (state)
      IDLE: begin
        if (any) begin
          fifo_pop_o = gnt_onehot;
          state_nxt  = SETUP;
        end
      end
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (m_pready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // APB drive, pointer update and response capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr         <= '0;
      gnt_q       <= '0;
      m_psel_o    <= 1'b0;
      m_penable_o <= 1'b0;
      m_pwrite_o  <= 1'b0;
      m_paddr_o   <= '0;
      m_pwdata_o  <= '0;
      rsp_valid_o <= 1'b0;
      rsp_port_o  <= '0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      rsp_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (any) begin
            gnt_q      <= gnt_idx;
            m_psel_o   <= 1'b1;
            m_paddr_o  <= sel_addr;
            m_pwdata_o <= sel_wdata;
            m_pwrite_o <= sel_write;
          end
        end
        SETUP: m_penable_o <= 1'b1;
        ACCESS: begin
          if (m_pready_i) begin
            m_psel_o    <= 1'b0;
            m_penable_o <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_port_o  <= gnt_q;
            rsp_rdata_o <= m_pwrite_o ? '0 : m_prdata_i;
            rsp_err_o   <= m_pslverr_i;
            ptr         <= (gnt_q == PORT_W'(NUM_PORTS - 1)) ? '0 : gnt_q + PORT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Randomized bench for apb_rr_arbiter against a transaction-level reference model.
module tb_apb_rr_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned PW = 2;
  localparam int unsigned QD = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    fifo_empty;
  logic [N*AW-1:0] fifo_addr;
  logic [N*DW-1:0] fifo_wdata;
  logic [N-1:0]    fifo_write;
  logic [N-1:0]    fifo_pop;
  logic            m_psel, m_penable, m_pwrite;
  logic [AW-1:0]   m_paddr;
  logic [DW-1:0]   m_pwdata, m_prdata;
  logic            m_pready, m_pslverr;
  logic            rsp_valid;
  logic [PW-1:0]   rsp_port;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;

  always #5 clk = ~clk;

  apb_rr_arbiter #(.NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .PORT_W(PW)) dut (
    .clk          (clk),
    .reset        (reset),
    .fifo_empty_i (fifo_empty),
    .fifo_addr_i  (fifo_addr),
    .fifo_wdata_i (fifo_wdata),
    .fifo_write_i (fifo_write),
    .fifo_pop_o   (fifo_pop),
    .m_psel_o     (m_psel),
    .m_penable_o  (m_penable),
    .m_pwrite_o   (m_pwrite),
    .m_paddr_o    (m_paddr),
    .m_pwdata_o   (m_pwdata),
    .m_prdata_i   (m_prdata),
    .m_pready_i   (m_pready),
    .m_pslverr_i  (m_pslverr),
    .rsp_valid_o  (rsp_valid),
    .rsp_port_o   (rsp_port),
    .rsp_rdata_o  (rsp_rdata),
    .rsp_err_o    (rsp_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Per-port FIFO contents as circular buffers.
  logic [AW-1:0] q_addr [N][QD];
  logic [DW-1:0] q_wdata[N][QD];
  logic          q_wr   [N][QD];
  int            hd[N];
  int            ct[N];

  // Transaction-level model state: 0 free, 1 address phase, 2 data phase.
  int            ptr_m;
  int            phase;
  int            nxt_phase;
  int            pop_port;
  int            cur_port;
  logic [AW-1:0] cur_addr;
  logic [DW-1:0] cur_wdata;
  logic          cur_wr;
  bit            rsp_pend, nxt_rsp;
  int            rsp_port_m;
  logic [DW-1:0] rsp_rd_m;
  logic          rsp_err_m;
  int            waits_left;

  // Stimulus knobs.
  int            wait_mode;   // <0 random wait states, else fixed count
  int            err_mode;    // 0 random, 1 force 0, 2 force 1
  bit            rd_fix_en;
  logic [DW-1:0] rd_fixed;
  bit            rand_push;

  task automatic push(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic w);
    if (ct[p] < int'(QD)) begin
      q_addr [p][(hd[p] + ct[p]) % QD] = a;
      q_wdata[p][(hd[p] + ct[p]) % QD] = d;
      q_wr   [p][(hd[p] + ct[p]) % QD] = w;
      ct[p]++;
    end
  endtask

  task automatic drive_fifo();
    for (int i = 0; i < int'(N); i++) begin
      fifo_empty[i] = (ct[i] == 0);
      if (ct[i] > 0) begin
        fifo_addr [i*AW +: AW] = q_addr [i][hd[i]];
        fifo_wdata[i*DW +: DW] = q_wdata[i][hd[i]];
        fifo_write[i]          = q_wr   [i][hd[i]];
      end
    end
  endtask

  function automatic int pick();
    for (int k = 0; k < int'(N); k++) begin
      if (ct[(ptr_m + k) % N] > 0) return (ptr_m + k) % N;
    end
    return -1;
  endfunction

  function automatic int total_pending();
    int s = 0;
    for (int i = 0; i < int'(N); i++) s += ct[i];
    return s;
  endfunction

  // Compare DUT outputs against the model for the current cycle.
  task automatic eval_cycle();
    int           g;
    logic [N-1:0] exp_pop;
    check_eq("rsp_valid", 64'(rsp_valid), 64'(rsp_pend));
    if (rsp_pend) begin
      check_eq("rsp_port", 64'(rsp_port), 64'(rsp_port_m));
      check_eq("rsp_rdata", 64'(rsp_rdata), 64'(rsp_rd_m));
      check_eq("rsp_err", 64'(rsp_err), 64'(rsp_err_m));
    end
    nxt_rsp   = 1'b0;
    nxt_phase = phase;
    pop_port  = -1;
    case (phase)
      0: begin
        g       = pick();
        exp_pop = (g >= 0) ? (N'(1) << g) : '0;
        check_eq("pop_grant", 64'(fifo_pop), 64'(exp_pop));
        check_eq("psel_idle", 64'(m_psel), 64'(0));
        check_eq("penable_idle", 64'(m_penable), 64'(0));
        if (g >= 0) begin
          cur_port  = g;
          cur_addr  = q_addr [g][hd[g]];
          cur_wdata = q_wdata[g][hd[g]];
          cur_wr    = q_wr   [g][hd[g]];
          pop_port  = g;
          nxt_phase = 1;
        end
      end
      1: begin
        check_eq("pop_setup", 64'(fifo_pop), 64'(0));
        check_eq("psel_setup", 64'(m_psel), 64'(1));
        check_eq("penable_setup", 64'(m_penable), 64'(0));
        check_eq("paddr_setup", 64'(m_paddr), 64'(cur_addr));
        check_eq("pwrite_setup", 64'(m_pwrite), 64'(cur_wr));
        check_eq("pwdata_setup", 64'(m_pwdata), 64'(cur_wdata));
        nxt_phase = 2;
      end
      default: begin
        check_eq("pop_access", 64'(fifo_pop), 64'(0));
        check_eq("psel_access", 64'(m_psel), 64'(1));
        check_eq("penable_access", 64'(m_penable), 64'(1));
        check_eq("paddr_access", 64'(m_paddr), 64'(cur_addr));
        check_eq("pwrite_access", 64'(m_pwrite), 64'(cur_wr));
        if (m_pready) begin
          nxt_rsp    = 1'b1;
          rsp_port_m = cur_port;
          rsp_rd_m   = cur_wr ? '0 : m_prdata;
          rsp_err_m  = m_pslverr;
          ptr_m      = (cur_port + 1) % N;
          nxt_phase  = 0;
        end
      end
    endcase
  endtask

  // Commit model updates after the clock edge and drive fresh inputs.
  task automatic advance();
    int old_phase;
    old_phase = phase;
    if (pop_port >= 0) begin
      hd[pop_port] = (hd[pop_port] + 1) % QD;
      ct[pop_port]--;
    end
    phase    = nxt_phase;
    rsp_pend = nxt_rsp;
    if (phase == 2 && old_phase == 1)
      waits_left = (wait_mode >= 0) ? wait_mode : int'($urandom_range(0, 3));
    if (phase == 2) begin
      if (waits_left > 0) begin
        m_pready = 1'b0;
        waits_left--;
      end else begin
        m_pready = 1'b1;
      end
    end else begin
      m_pready = 1'($urandom_range(0, 1));
    end
    m_prdata  = rd_fix_en ? rd_fixed : $urandom;
    m_pslverr = (err_mode == 0) ? 1'($urandom_range(0, 1)) : (err_mode == 2);
    if (rand_push && $urandom_range(0, 2) == 0)
      push(int'($urandom_range(0, N - 1)), $urandom, $urandom, 1'($urandom_range(0, 1)));
    drive_fifo();
  endtask

  task automatic step();
    @(negedge clk);
    eval_cycle();
    @(posedge clk);
    #1;
    advance();
  endtask

  task automatic run_until_drained(input string tag, input int budget);
    int n = 0;
    while ((phase != 0 || rsp_pend || total_pending() > 0) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) check_eq({tag, "_timeout"}, 64'(1), 64'(0));
    step();
    check_eq({tag, "_drained"}, 64'(total_pending()), 64'(0));
  endtask

  task automatic model_reset();
    ptr_m      = 0;
    phase      = 0;
    rsp_pend   = 1'b0;
    nxt_rsp    = 1'b0;
    nxt_phase  = 0;
    pop_port   = -1;
    waits_left = 0;
  endtask

  initial begin
    int n;
    reset      = 1'b0;
    fifo_empty = '1;
    fifo_addr  = '0;
    fifo_wdata = '0;
    fifo_write = '0;
    m_prdata   = '0;
    m_pready   = 1'b1;
    m_pslverr  = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      hd[i] = 0;
      ct[i] = 0;
    end
    model_reset();
    wait_mode = 0;
    err_mode  = 1;
    rd_fix_en = 1'b0;
    rd_fixed  = '0;
    rand_push = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_psel", 64'(m_psel), 64'(0));
    check_eq("rst_penable", 64'(m_penable), 64'(0));
    check_eq("rst_pwrite", 64'(m_pwrite), 64'(0));
    check_eq("rst_paddr", 64'(m_paddr), 64'(0));
    check_eq("rst_pwdata", 64'(m_pwdata), 64'(0));
    check_eq("rst_pop", 64'(fifo_pop), 64'(0));
    check_eq("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check_eq("rst_rsp_port", 64'(rsp_port), 64'(0));
    check_eq("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
    check_eq("rst_rsp_err", 64'(rsp_err), 64'(0));
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Single write on port 2 with immediate PREADY.
    push(2, 32'h1000_0010, 32'hDEAD_BEEF, 1'b1);
    drive_fifo();
    run_until_drained("single_wr", 20);

    // All ports with two entries each, zero wait states.
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < int'(N); p++)
        push(p, 32'h100 * (p + 1) + 32'(r * 4), $urandom, 1'($urandom_range(0, 1)));
    drive_fifo();
    run_until_drained("all_ports", 60);

    // Read on port 1 with three wait states.
    wait_mode = 3;
    rd_fix_en = 1'b1;
    rd_fixed  = 32'h1234_5678;
    push(1, 32'h20, 32'h0, 1'b0);
    drive_fifo();
    run_until_drained("rd_wait", 30);
    wait_mode = 0;
    rd_fix_en = 1'b0;

    // Slave error on port 3, then port 0 must beat port 1.
    err_mode = 2;
    push(3, 32'h300, 32'hA5A5_0003, 1'b1);
    drive_fifo();
    run_until_drained("err_p3", 20);
    err_mode = 1;
    push(0, 32'h400, 32'h0000_0400, 1'b1);
    push(1, 32'h500, 32'h0000_0500, 1'b0);
    drive_fifo();
    run_until_drained("after_err", 30);

    // Sparse fairness: port 3 served, then ports 0 and 3 compete.
    push(3, 32'h600, 32'h0000_0600, 1'b0);
    drive_fifo();
    run_until_drained("sparse_p3", 20);
    push(0, 32'h700, 32'h0000_0700, 1'b1);
    push(3, 32'h800, 32'h0000_0800, 1'b1);
    drive_fifo();
    run_until_drained("sparse_03", 30);

    // Reset during ACCESS with PREADY low; pointer parked at 2 beforehand.
    push(1, 32'h900, 32'h0000_0900, 1'b1);
    drive_fifo();
    run_until_drained("pre_rst", 20);
    wait_mode = 50;
    push(1, 32'hA00, 32'h0000_0A00, 1'b0);
    drive_fifo();
    n = 0;
    while (phase != 2 && n < 10) begin
      step();
      n++;
    end
    if (phase != 2) check_eq("rst_reach_access", 64'(phase), 64'(2));
    step();
    reset = 1'b0;
    #1;
    check_eq("midrst_psel", 64'(m_psel), 64'(0));
    check_eq("midrst_penable", 64'(m_penable), 64'(0));
    check_eq("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
    repeat (2) begin
      @(posedge clk);
      #1;
      check_eq("inrst_rsp_valid", 64'(rsp_valid), 64'(0));
      check_eq("inrst_psel", 64'(m_psel), 64'(0));
    end
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    wait_mode = 0;
    @(posedge clk);
    #1;
    check_eq("postrst_rsp_valid", 64'(rsp_valid), 64'(0));
    m_pready = 1'b1;
    push(2, 32'hB00, 32'h0000_0B00, 1'b1);
    push(0, 32'hC00, 32'h0000_0C00, 1'b0);
    drive_fifo();
    run_until_drained("post_rst", 30);

    // Random traffic with random wait states, errors and read data.
    wait_mode = -1;
    err_mode  = 0;
    rand_push = 1'b1;
    repeat (400) step();
    rand_push = 1'b0;
    run_until_drained("random", 400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
